// File: rtl/wb_responder_pkg.sv
// Shared types and widths for the wb_responder Wishbone classic-cycle slave.
package wb_responder_pkg;

  localparam int unsigned WB_DATA_WIDTH     = 32;
  localparam int unsigned WB_SEL_WIDTH      = 4;
  localparam int unsigned WB_WAIT_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    TERM
  } state_e;

  // Request fields captured at acceptance; oor/retry decide the termination kind.
  typedef struct packed {
    logic [WB_DATA_WIDTH-1:0] dat;
    logic [WB_SEL_WIDTH-1:0]  sel;
    logic                     we;
    logic                     oor;
    logic                     retry;
  } wb_req_t;

endpackage

// File: rtl/wb_responder_if.sv
// Wishbone classic-cycle bus bundle between an initiator (master) and wb_responder (slave).
interface wb_responder_if;
  import wb_responder_pkg::*;

  logic [WB_DATA_WIDTH-1:0] adr;
  logic [WB_DATA_WIDTH-1:0] din;
  logic [WB_DATA_WIDTH-1:0] dout;
  logic                     cyc;
  logic                     stb;
  logic [WB_SEL_WIDTH-1:0]  sel;
  logic                     we;
  logic                     ack;
  logic                     err;
  logic                     rty;

  modport master (
    output adr, din, cyc, stb, sel, we,
    input  dout, ack, err, rty
  );

  modport slave (
    input  adr, din, cyc, stb, sel, we,
    output dout, ack, err, rty
  );

endinterface

// File: rtl/wb_responder_mem.sv
// Single-port word memory with per-byte write enables; synchronous write, combinational read.
module wb_responder_mem
  import wb_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [WB_SEL_WIDTH-1:0]  sel,
  input  logic [ADDR_WIDTH-1:0]    index,
  input  logic [WB_DATA_WIDTH-1:0] wdata,
  output logic [WB_DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

  logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(WB_SEL_WIDTH); i++) begin
        if (sel[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/wb_responder.sv
// Wishbone classic-cycle slave: byte-writable memory, programmable wait states, err on
// out-of-range addresses. Optional periodic rty termination under WB_RESPONDER_RETRY_EN.
module wb_responder
  import wb_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned RETRY_PERIOD = 4
) (
  input logic           clk,
  input logic           rst_n,
  wb_responder_if.slave bus
);

  state_e                         state, state_d;
  logic [WB_WAIT_CNT_WIDTH-1:0]   cnt, cnt_d;
  wb_req_t                        req_q, req_d, new_req, cur_req;
  logic [ADDR_WIDTH-1:0]          idx_q, idx_d, new_idx, cur_idx;
  logic                           term_c;
  logic                           ack_d, err_d, rty_d;
  logic [WB_DATA_WIDTH-1:0]       dout_d;
  logic                           mem_we_c;
  logic [WB_DATA_WIDTH-1:0]       rdata_c;
  logic                           unused_adr;

  assign unused_adr = ^bus.adr[1:0];
  assign new_idx    = bus.adr[ADDR_WIDTH+1:2];

`ifdef WB_RESPONDER_RETRY_EN
  localparam logic [7:0] RETRY_LAST = 8'(RETRY_PERIOD - 1);
  logic [7:0] acc_q, acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`else
  logic [7:0] unused_retry;
  assign unused_retry = 8'(RETRY_PERIOD);
`endif

  // Next-state, request capture and termination decode.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    req_d    = req_q;
    idx_d    = idx_q;
    term_c   = 1'b0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rty_d    = 1'b0;
    dout_d   = '0;
    mem_we_c = 1'b0;

    new_req = '{dat:   bus.din,
                sel:   bus.sel,
                we:    bus.we,
                oor:   |bus.adr[WB_DATA_WIDTH-1:ADDR_WIDTH+2],
                retry: 1'b0};

`ifdef WB_RESPONDER_RETRY_EN
    acc_d = acc_q;
    if (state == IDLE && bus.cyc && bus.stb && !new_req.oor) begin
      if (acc_q == RETRY_LAST) begin
        new_req.retry = 1'b1;
        acc_d         = '0;
      end else begin
        acc_d = acc_q + 8'd1;
      end
    end
`endif

    // With zero wait states the live bus request is terminated straight from IDLE.
    cur_req = (state == IDLE) ? new_req : req_q;
    cur_idx = (state == IDLE) ? new_idx : idx_q;

    unique case (state)
      IDLE: begin
        if (bus.cyc && bus.stb) begin
          req_d = new_req;
          idx_d = new_idx;
          cnt_d = WB_WAIT_CNT_WIDTH'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d = TERM;
            term_c  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Abort wins over a coincident final wait edge.
        if (!(bus.cyc && bus.stb)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt <= 4'd1) begin
          state_d = TERM;
          term_c  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      TERM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (term_c) begin
      if (cur_req.oor) begin
        err_d = 1'b1;
      end else if (cur_req.retry) begin
        rty_d = 1'b1;
      end else begin
        ack_d    = 1'b1;
        mem_we_c = cur_req.we;
        if (!cur_req.we) dout_d = rdata_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      req_q    <= '0;
      idx_q    <= '0;
      bus.ack  <= 1'b0;
      bus.err  <= 1'b0;
      bus.rty  <= 1'b0;
      bus.dout <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      req_q    <= req_d;
      idx_q    <= idx_d;
      bus.ack  <= ack_d;
      bus.err  <= err_d;
      bus.rty  <= rty_d;
      bus.dout <= dout_d;
    end
  end

  wb_responder_mem #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .sel   (cur_req.sel),
    .index (cur_idx),
    .wdata (cur_req.dat),
    .rdata (rdata_c)
  );

endmodule

// File: tb/tb_wb_responder.sv
// Self-checking bench for wb_responder: two instances (1 and 3 wait states) on separate buses.
module tb_wb_responder;

  localparam int unsigned AW = 6;
  localparam int unsigned RP = 4;
  localparam logic [2:0] T_ACK = 3'b100;
  localparam logic [2:0] T_ERR = 3'b010;
  localparam logic [2:0] T_RTY = 3'b001;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wb_responder_if b1 ();
  wb_responder_if b3 ();

  wb_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(1), .RETRY_PERIOD(RP)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  wb_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(3), .RETRY_PERIOD(RP)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );

  typedef struct {
    logic [2:0]  term;
    logic [31:0] dout;
    bit          chk_dout;
    int          lat;
    string       name;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  t;
    logic [31:0] q;
    bit          cq;
    string       nm;
  } vec_t;

  exp_t sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input int dv, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
    if (dv == 1) begin
      b1.cyc = c; b1.stb = s; b1.we = w; b1.adr = a; b1.din = d; b1.sel = sl;
    end else begin
      b3.cyc = c; b3.stb = s; b3.we = w; b3.adr = a; b3.din = d; b3.sel = sl;
    end
  endtask

  function automatic logic [2:0] term_of(input int dv);
    return (dv == 1) ? {b1.ack, b1.err, b1.rty} : {b3.ack, b3.err, b3.rty};
  endfunction

  function automatic logic [31:0] dout_of(input int dv);
    return (dv == 1) ? b1.dout : b3.dout;
  endfunction

  // One classic cycle: expectation queued at issue, popped when the DUT terminates.
  task automatic xfer(input int dv, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] sl, input logic [2:0] et, input logic [31:0] ed,
                      input bit cd, input string nm);
    exp_t       e;
    logic [2:0] t;
    logic [31:0] q;
    int         n;
    sb.push_back('{term: et, dout: ed, chk_dout: cd, lat: (dv == 1) ? 2 : 4, name: nm});
    @(posedge clk); #1;
    drive(dv, 1'b1, 1'b1, w, a, d, sl);
    n = 0;
    t = 3'b000;
    q = '0;
    while (n < 20) begin
      @(negedge clk);
      t = term_of(dv);
      q = dout_of(dv);
      if (t != 3'b000) break;
      n++;
    end
    e = sb.pop_front();
    check({e.name, " term"}, 32'(t), 32'(e.term));
    check({e.name, " latency"}, 32'(n), 32'(e.lat));
    if (e.chk_dout) check({e.name, " dout"}, q, e.dout);
    drive(dv, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check({e.name, " single-cycle term"}, 32'(term_of(dv)), 32'h0);
  endtask

`ifdef WB_RESPONDER_RETRY_EN
  int          acc_mdl = 0;
  logic [31:0] mmdl [64];
  bit          mval [64];

  function automatic logic [2:0] mdl_term(input logic [31:0] a);
    logic [31:0] hi;
    hi = a >> (AW + 2);
    if (hi != 0) return T_ERR;
    if (acc_mdl == int'(RP) - 1) begin
      acc_mdl = 0;
      return T_RTY;
    end
    acc_mdl++;
    return T_ACK;
  endfunction

  task automatic retry_seq();
    logic [31:0] a;
    logic [2:0]  t;
    int          ix;
    for (int i = 0; i < 9; i++) begin
      a = (i == 2) ? 32'h100 : 32'h40 + 32'(4 * i);
      t = mdl_term(a);
      ix = int'(a[AW+1:2]);
      if (t == T_ACK) begin
        mmdl[ix] = 32'hA000_0000 + 32'(i);
        mval[ix] = 1'b1;
      end
      xfer(1, 1'b1, a, 32'hA000_0000 + 32'(i), 4'hF, t, 32'h0, 1'b0, $sformatf("retry wr%0d", i));
    end
    for (int i = 0; i < 9; i++) begin
      if (i == 2) continue;
      a = 32'h40 + 32'(4 * i);
      t = mdl_term(a);
      ix = int'(a[AW+1:2]);
      xfer(1, 1'b0, a, 32'h0, 4'hF, t, (t == T_ACK) ? mmdl[ix] : 32'h0,
           (t != T_ACK) || mval[ix], $sformatf("retry rd%0d", i));
    end
  endtask
`endif

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t       tbl[$];
    logic [5:0] hits;
    bit         seen;

    rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    check("reset b1 term", 32'(term_of(1)), 32'h0);
    check("reset b1 dout", dout_of(1), 32'h0);
    check("reset b3 term", 32'(term_of(3)), 32'h0);
    check("reset b3 dout", dout_of(3), 32'h0);
    rst_n = 1'b1;

`ifdef WB_RESPONDER_RETRY_EN
    retry_seq();
`else
    tbl.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, T_ACK, 32'h0, 1'b0, "wr 0x10"});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, T_ACK, 32'hDEAD_BEEF, 1'b1, "rd 0x10"});
    tbl.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, T_ACK, 32'h0, 1'b0, "preload 0x20"});
    tbl.push_back('{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, T_ACK, 32'h0, 1'b0, "lanes 0101"});
    tbl.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'hF, T_ACK, 32'h11BB_33DD, 1'b1, "rd lanes"});
    tbl.push_back('{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, T_ACK, 32'h0, 1'b0, "wr sel0"});
    tbl.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'hF, T_ACK, 32'h11BB_33DD, 1'b1, "rd after sel0"});
    tbl.push_back('{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, T_ACK, 32'h0, 1'b0, "wr 0x0"});
    tbl.push_back('{1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF, T_ERR, 32'h0, 1'b1, "wr oor 0x100"});
    tbl.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'hF, T_ACK, 32'hCAFE_F00D, 1'b1, "rd 0x0"});
    tbl.push_back('{1'b0, 32'h0000_0100, 32'h0,         4'hF, T_ERR, 32'h0, 1'b1, "rd oor 0x100"});
    tbl.push_back('{1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 4'hF, T_ACK, 32'h0, 1'b0, "wr top word"});
    tbl.push_back('{1'b0, 32'h0000_00FC, 32'h0,         4'hF, T_ACK, 32'h0BAD_F00D, 1'b1, "rd top word"});
    tbl.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'hF, T_ACK, 32'hDEAD_BEEF, 1'b1, "rd adr lsb ignored"});
    tbl.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, T_ERR, 32'h0, 1'b1, "rd oor high"});
    tbl.push_back('{1'b1, 32'h0000_0020, 32'h9900_7700, 4'hA, T_ACK, 32'h0, 1'b0, "lanes 1010"});
    tbl.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'hF, T_ACK, 32'h9900_7700 | 32'h00BB_00DD, 1'b1, "rd lanes 1010"});

    for (int i = 0; i < tbl.size(); i++)
      xfer(1, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].t, tbl[i].q, tbl[i].cq, tbl[i].nm);

    // Held strobe: terminations every WAIT_STATES+2 cycles.
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    hits = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      hits[k] = b1.ack;
    end
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("back-to-back ack cycles", 32'(hits), 32'h24);

    xfer(3, 1'b1, 32'h8, 32'h1234_5678, 4'hF, T_ACK, 32'h0, 1'b0, "ws3 wr 0x8");
    xfer(3, 1'b0, 32'h8, 32'h0, 4'hF, T_ACK, 32'h1234_5678, 1'b1, "ws3 rd 0x8");
    xfer(3, 1'b1, 32'h400, 32'h1, 4'hF, T_ERR, 32'h0, 1'b1, "ws3 wr oor");

    // Abort: strobe dropped after one wait cycle.
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b1, 1'b1, 32'h8, 32'h5, 4'hF);
    repeat (2) @(negedge clk);
    drive(3, 1'b1, 1'b0, 1'b1, 32'h8, 32'h5, 4'hF);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen = seen | (|term_of(3));
    end
    drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("abort no termination", 32'(seen), 32'h0);
    xfer(3, 1'b0, 32'h8, 32'h0, 4'hF, T_ACK, 32'h1234_5678, 1'b1, "rd 0x8 after abort");

    // Reset asserted mid ack cycle drops the outputs at once.
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      seen = b1.ack;
    end
    check("pre-reset ack dout", dout_of(1), 32'hDEAD_BEEF);
    #2 rst_n = 1'b0;
    #1;
    check("reset in ack term", 32'(term_of(1)), 32'h0);
    check("reset in ack dout", dout_of(1), 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WAIT discards the in-flight write.
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b1, 1'b1, 32'h8, 32'h77, 4'hF);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset in wait term", 32'(term_of(3)), 32'h0);
    check("reset in wait dout", dout_of(3), 32'h0);
    drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(3, 1'b0, 32'h8, 32'h0, 4'hF, T_ACK, 32'h1234_5678, 1'b1, "rd 0x8 after reset");
    xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, T_ACK, 32'hCAFE_F00D, 1'b1, "ws1 rd after reset");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_responder.md
Name: wb_responder

Overview:
- Synthesizable Wishbone classic-cycle slave. It is the responder end of the bus that the wishbone_driver initiates on.
- Backs a byte-lane-writable word memory and adds programmable wait states and error termination for out-of-range addresses.
- Sits in the testbench top as a second bus target beside uart_top, so the driver's wait-state, err and (optionally) retry paths can be exercised.

Parameters:
- ADDR_WIDTH, 6, word-index bits; memory depth is 2**ADDR_WIDTH words of 32 bits.
- WAIT_STATES, 1, idle cycles between acceptance and termination; legal range 0..15.
- RETRY_PERIOD, 4, used only with the optional feature: every RETRY_PERIOD-th accepted access terminates with rty; legal range 2..255.

Ports:
- clk  input  1  bus clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- adr  input  32  byte address; adr[1:0] ignored.
- din  input  32  write data from the initiator.
- dout  output  32  read data; valid only while ack is high.
- cyc  input  1  bus cycle in progress.
- stb  input  1  strobe.
- sel  input  4  byte-lane enables; sel[0] is bits 7:0.
- we  input  1  1 = write, 0 = read.
- ack  output  1  normal termination.
- err  output  1  error termination.
- rty  output  1  retry termination; tied to 0 unless the optional feature is compiled in.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: ack=0, err=0, rty=0, dout=0, state=IDLE, wait counter=0, access counter=0. Memory contents are not reset; reads of unwritten words return X.
- Decode: word index = adr[ADDR_WIDTH+1:2]. Address is in range iff adr[31:ADDR_WIDTH+2]==0.
- States:
  - IDLE: if cyc&stb at a clock edge, latch adr/din/sel/we. Go to WAIT, or to TERM if WAIT_STATES==0. Load the wait counter with WAIT_STATES.
  - WAIT: decrement the counter each cycle. When it reaches 1, go to TERM. If cyc or stb is low at any edge, abort to IDLE with no termination and no write.
  - TERM: exactly one of ack/err/rty is high for exactly one cycle. Then return to IDLE unconditionally.
- Termination outputs are registered. With WAIT_STATES=N, the termination signal is high in the (N+1)th cycle after the cycle where cyc&stb was first sampled.
- Termination select: err if the address is out of range; else rty (feature only); else ack.
- Write: committed at the edge entering TERM, only when terminating with ack. Each lane with sel[i]=1 updates byte i. sel=4'b0000 still acks but changes nothing.
- Read: dout = mem[index] during the ack cycle; 0 in all other cycles, including err/rty cycles. Data is read in the entry-to-TERM cycle, so a write and a read to the same word return the post-write value.
- Back-to-back: the mandatory IDLE cycle after TERM means a continuously held stb is re-accepted one cycle after termination. Peak throughput is one transfer per WAIT_STATES+2 cycles.
- Inputs are ignored outside IDLE, except the cyc/stb abort check in WAIT.
- Reset mid-operation: the asynchronous assertion drops all outputs immediately. An in-flight write is discarded.
- The response to simultaneous cyc deassertion and the final wait edge is an abort, not a termination.

Optional Feature:
- Macro: WB_RESPONDER_RETRY_EN.
- Defined: an 8-bit access counter increments on every in-range acceptance. When the count modulo RETRY_PERIOD equals RETRY_PERIOD-1, that access terminates with rty: no write, dout=0, and the counter wraps to 0. Out-of-range accesses do not count.
- Undefined: the counter is absent, rty is constant 0, and every in-range access acks.

Decomposition:
- Package wb_responder_pkg:
  - state enum {IDLE, WAIT, TERM};
  - WB_DATA_WIDTH=32, WB_SEL_WIDTH=4;
  - wait-counter width constant (4 bits).
- Sub-module wb_responder_mem: single-port, byte-enabled synchronous RAM with ports clk, we, sel, index, wdata, rdata, parameterized by ADDR_WIDTH. The FSM and termination logic stay in wb_responder.

Test Plan:
- Write then read, WAIT_STATES=1: write 0xDEADBEEF to adr 0x10 with sel=4'hF, then read 0x10 → ack high in the 2nd cycle after stb; dout=0xDEADBEEF in the ack cycle; err=rty=0.
- Byte lanes: preload 0x11223344 at 0x20, write 0xAABBCCDD with sel=4'b0101 → readback 0x11BB33DD. A write with sel=0 acks and readback is unchanged.
- Out of range, ADDR_WIDTH=6: write to adr 0x100 → err for one cycle, no ack. A subsequent read of 0x000 is unaffected. dout=0 during err.
- Abort: WAIT_STATES=3, drop stb after 1 wait cycle of a write of 0x5 to 0x8 → no ack/err/rty ever. Readback of 0x8 shows the old value.
- Reset mid-wait: assert rst_n=0 asynchronously mid-cycle during WAIT → ack/err/rty/dout go to 0 immediately. The next transaction after release completes normally with WAIT_STATES latency.
- With WB_RESPONDER_RETRY_EN, RETRY_PERIOD=4: six in-range writes → accesses 1–3 ack, access 4 rty with no write, accesses 5–6 ack. The pattern repeats.
